// File: rtl/cacheline_adapter.sv
// Purpose: cache line port (256b) to banked burst memory (4 x 64b beats), one transaction in flight.
// Latency: write resp 5 cycles after request with bmem_ready high; read resp 1 cycle after 4th beat.
// Backpressure: bmem_ready low holds the current command/beat unchanged; the cache holds its request until ufp_resp.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   ufp_*             - cache-facing line port (addr, read, write, wdata in; rdata, resp out)
//   bmem_addr/read/write/wdata/ready - burst command and write-beat channel
//   bmem_raddr/rdata/rvalid          - returning read beats
//
// Optional build macro: CACHELINE_ADAPTER_RADDR_CHECK_EN
//   When defined, a returning read beat is only taken if bmem_raddr[31:5]
//   matches the line being fetched; other beats are dropped without
//   advancing the beat counter. When undefined, bmem_raddr is ignored.
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  ufp_addr,
    input  logic         ufp_read,
    input  logic         ufp_write,
    input  logic [255:0] ufp_wdata,
    output logic [255:0] ufp_rdata,
    output logic         ufp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;       // beat index within the burst
    logic [26:0]    line_q, line_d;     // latched line address bits [31:5]
    logic [255:0]   buf_q, buf_d;       // read line under assembly
    logic [255:0]   rdata_q, rdata_d;   // last completed read line, shown on ufp_rdata

    logic           beat_ok;            // returning read beat is taken this cycle
    logic [7:0]     beat_lsb;           // bit offset of beat cnt_q within a line

    // Low address bits are don't-care by construction; the tag bits are only
    // consulted when the address check is built in.
    logic           unused_bits;
    assign unused_bits = ^{ufp_addr[4:0], bmem_raddr};

    assign beat_lsb = {cnt_q, 6'b0};

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    // A beat tagged for some other line (e.g. a stray response) must not be
    // folded into this line, so it is simply not counted.
    assign beat_ok = bmem_rvalid && (bmem_raddr[31:5] == line_q);
`else
    assign beat_ok = bmem_rvalid;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            line_q  <= 27'd0;
            buf_q   <= 256'd0;
            rdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        ufp_resp   = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = 32'd0;
        bmem_wdata = 64'd0;

        case (state_q)
            IDLE: begin
                // Requests are only looked at here, so the request still
                // high during RESP can never start a second transaction.
                if (ufp_write) begin
                    line_d  = ufp_addr[31:5];
                    cnt_d   = 2'd0;
                    state_d = WR;
                end else if (ufp_read) begin
                    line_d  = ufp_addr[31:5];
                    state_d = RD_REQ;
                end
            end

            WR: begin
                bmem_write = 1'b1;
                bmem_addr  = {line_q, 5'b0};
                // The cache keeps wdata stable for the whole request, so
                // beats are sliced straight from its port, no local copy.
                bmem_wdata = ufp_wdata[beat_lsb +: 64];
                if (bmem_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = RESP;
                    end
                end
            end

            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = {line_q, 5'b0};
                if (bmem_ready) begin
                    cnt_d   = 2'd0;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (beat_ok) begin
                    buf_d[beat_lsb +: 64] = bmem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Publish the full line only once it is complete so
                        // ufp_rdata keeps the previous line during a fetch.
                        rdata_d = buf_d;
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                ufp_resp = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ufp_rdata = rdata_q;

    // The burst port carries either a read command or a write beat, never both.
    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bmem_read && bmem_write));

    // Completion is a single-cycle pulse.
    a_resp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        ufp_resp |=> !ufp_resp);

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: table of line transactions plus a mid-read
// reset sequence; expected beats, commands and responses are queued when a
// request is driven and checked by a negedge monitor as the DUT emits them.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  ufp_addr;
    logic         ufp_read;
    logic         ufp_write;
    logic [255:0] ufp_wdata;
    logic [255:0] ufp_rdata;
    logic         ufp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ufp_addr    (ufp_addr),
        .ufp_read    (ufp_read),
        .ufp_write   (ufp_write),
        .ufp_wdata   (ufp_wdata),
        .ufp_rdata   (ufp_rdata),
        .ufp_resp    (ufp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    typedef struct {
        logic         wr;
        logic         rd;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rline;      // line the memory returns for a read
        int           gap;        // cycles from accepted command to first beat
        int           stall_beat; // beat (or command, for 0 on reads) stalled by bmem_ready
        int           stall_len;  // stalled cycles
        int           exp_lat;    // expected cycles from request to ufp_resp
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    beat_t        exp_beats[$];
    logic [31:0]  exp_cmds[$];
    logic [255:0] exp_resps[$];

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    bit           resp_seen;
    int           resp_cycle;
    logic [255:0] last_rd = 256'd0;

    logic [255:0] mem_line;
    int           mem_gap;
    bit           mem_bad = 1'b0;
    bit           mem_busy = 1'b0;
    logic [31:0]  mem_addr;

    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bmem_read || bmem_write)
                chk("rd_wr_exclusive", {255'd0, bmem_read & bmem_write}, 256'd0);
            if (bmem_write) begin
                if (exp_beats.size() == 0) begin
                    fail_now("unexpected_write_beat");
                end else begin
                    chk("beat_addr", bmem_addr, exp_beats[0].addr);
                    chk(bmem_ready ? "beat_data" : "stall_hold_data", bmem_wdata, exp_beats[0].data);
                    if (bmem_ready) void'(exp_beats.pop_front());
                end
            end
            if (bmem_read) begin
                if (exp_cmds.size() == 0) begin
                    fail_now("unexpected_read_cmd");
                end else begin
                    chk("read_cmd_addr", bmem_addr, exp_cmds[0]);
                    if (bmem_ready) void'(exp_cmds.pop_front());
                end
            end
            if (ufp_resp) begin
                resp_seen  = 1'b1;
                resp_cycle = cyc;
                if (exp_resps.size() == 0) fail_now("unexpected_resp");
                else chk("resp_rdata", ufp_rdata, exp_resps.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Burst memory read responder
    // ------------------------------------------------------------------
    initial begin
        bmem_rvalid = 1'b0;
        bmem_rdata  = 64'd0;
        bmem_raddr  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && bmem_read && bmem_ready) begin
                mem_busy = 1'b1;
                mem_addr = bmem_addr;
                repeat (mem_gap) @(posedge clk);
                #2;
                for (int b = 0; b < 4; b++) begin
                    if (b > 0) begin
                        @(posedge clk); #2;
                    end
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = mem_line[64*b +: 64];
                    bmem_raddr  = mem_addr + 32'(8 * b);
                    if (b == 1 && mem_bad) begin
                        // stray beat tagged for another line
                        @(posedge clk); #2;
                        bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                        bmem_raddr = mem_addr ^ 32'h0000_0100;
                    end
                end
                @(posedge clk); #2;
                bmem_rvalid = 1'b0;
                bmem_rdata  = 64'd0;
                mem_busy    = 1'b0;
            end
        end
    end

    task automatic wait_mem_idle();
        int t = 0;
        while (mem_busy && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (mem_busy) fail_now("mem_idle_timeout");
        @(posedge clk); #2;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int c0;
        int t;
        int off;
        logic [31:0] la;
        la = {v.addr[31:5], 5'b0};
        if (v.wr) begin
            for (int b = 0; b < 4; b++) exp_beats.push_back(beat_t'({la, v.wdata[64*b +: 64]}));
            exp_resps.push_back(last_rd);
        end else begin
            exp_cmds.push_back(la);
            last_rd = v.rline;
            exp_resps.push_back(v.rline);
        end
        mem_line  = v.rline;
        mem_gap   = v.gap;
        resp_seen = 1'b0;
        @(posedge clk); #2;
        ufp_addr  = v.addr;
        ufp_write = v.wr;
        ufp_read  = v.rd;
        ufp_wdata = v.wdata;
        c0 = cyc;
        t  = 0;
        do begin
            @(posedge clk); #2;
            t++;
            off = cyc - c0;
            bmem_ready = !(off >= 1 + v.stall_beat && off < 1 + v.stall_beat + v.stall_len);
        end while (!resp_seen && t < 200);
        ufp_write  = 1'b0;
        ufp_read   = 1'b0;
        bmem_ready = 1'b1;
        if (!resp_seen) fail_now({name, "_resp_timeout"});
        else chk({name, "_latency"}, 256'(resp_cycle - c0), 256'(v.exp_lat));
        wait_mem_idle();
        chk({name, "_beats_left"}, 256'(exp_beats.size()), 256'd0);
        chk({name, "_cmds_left"}, 256'(exp_cmds.size()), 256'd0);
        chk({name, "_resps_left"}, 256'(exp_resps.size()), 256'd0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_resp"}, {255'd0, ufp_resp}, 256'd0);
        chk({name, "_bmem_read"}, {255'd0, bmem_read}, 256'd0);
        chk({name, "_bmem_write"}, {255'd0, bmem_write}, 256'd0);
        chk({name, "_bmem_addr"}, {224'd0, bmem_addr}, 256'd0);
        chk({name, "_bmem_wdata"}, {192'd0, bmem_wdata}, 256'd0);
        chk({name, "_rdata"}, ufp_rdata, 256'd0);
    endtask

    initial begin : stim
        vec_t v;
        int   c0;
        // fields: wr, rd, addr, wdata, rline, gap, stall_beat, stall_len, exp_lat
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1040,
                    {64'h4, 64'h3, 64'h2, 64'h1}, 256'd0, 0, 0, 0, 5};
        vecs[1] = '{1'b0, 1'b1, 32'h8000_00E4, 256'd0,
                    {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                     64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A}, 3, 0, 0, 8};
        vecs[2] = '{1'b1, 1'b0, 32'h1234_5678,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}, 256'd0, 0, 1, 2, 7};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0FFF,
                    {64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                     64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF}, 256'd0, 0, 0, 0, 5};
        vecs[4] = '{1'b0, 1'b1, 32'h4000_0020, 256'd0,
                    {64'h4444_4444_0000_0004, 64'h3333_3333_0000_0003,
                     64'h2222_2222_0000_0002, 64'h1111_1111_0000_0001}, 1, 0, 1, 7};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFC0,
                    {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                     64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000}, 256'd0, 0, 3, 1, 6};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 256'd0,
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                     64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE}, 2, 0, 0, 7};

        rst_n      = 1'b0;
        ufp_addr   = 32'd0;
        ufp_read   = 1'b0;
        ufp_write  = 1'b0;
        ufp_wdata  = 256'd0;
        bmem_ready = 1'b1;
        mem_line   = 256'd0;
        mem_gap    = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during beat 2 of a read: no response, outputs cleared,
        // remaining beats ignored, and a following read is intact.
        exp_cmds.push_back(32'h0000_2000);
        mem_line = {64'h9999, 64'h8888, 64'h7777, 64'h6666};
        mem_gap  = 1;
        @(posedge clk); #2;
        ufp_addr = 32'h0000_2010;
        ufp_read = 1'b1;
        c0 = cyc;
        repeat (4) @(posedge clk);
        #2;
        chk("rst_seq_on_beat2", 256'(cyc - c0), 256'd4);
        rst_n    = 1'b0;
        ufp_read = 1'b0;
        @(posedge clk); #2;
        rst_n   = 1'b1;
        last_rd = 256'd0;
        @(negedge clk);
        chk_idle_outputs("mid_read_reset");
        wait_mem_idle();
        chk("rst_cmds_left", 256'(exp_cmds.size()), 256'd0);
        v = '{1'b0, 1'b1, 32'h0000_3000, 256'd0,
              {64'h0D0D, 64'h0C0C, 64'h0B0B, 64'h0A0A}, 1, 0, 0, 6};
        run_vec("after_reset_read", v);

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
        mem_bad = 1'b1;
        v = '{1'b0, 1'b1, 32'h0000_5040, 256'd0,
              {64'h0000_0000_0000_0D0D, 64'h0000_0000_0000_0C0C,
               64'h0000_0000_0000_0B0B, 64'h0000_0000_0000_0A0A}, 1, 0, 0, 7};
        run_vec("raddr_mismatch_drop", v);
        mem_bad = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Responder for the cache's downstream line port: accepts one 256-bit line read or write from the cache and converts it into a 4-beat, 64-bit burst on the banked memory interface. Sits between the cache's downstream port and burst memory, one instance per cache. It answers the same hold-until-resp handshake the cache issues. Only one transaction is in flight at a time.

## Interface
- No parameters. Line width is fixed at 256 bits, beat width at 64 bits, 4 beats per line.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- ufp_addr  in  32  line address from the cache; bits [4:0] ignored
- ufp_read  in  1  line read request; held until ufp_resp
- ufp_write  in  1  line write request; held until ufp_resp
- ufp_wdata  in  256  write line; stable while ufp_write is high
- ufp_rdata  out  256  read line; valid when ufp_resp is high after a read
- ufp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst address, {line[31:5], 5'b0}
- bmem_read  out  1  burst read command
- bmem_write  out  1  burst write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts the command or beat this cycle
- bmem_raddr  in  32  address tag of the returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

## Operation
- States: IDLE, WR, RD_REQ, RD_WAIT, RESP. Reset enters IDLE.
- IDLE:
  - Requests are sampled only in this state. The line address is latched as {ufp_addr[31:5], 5'b0}.
  - ufp_write goes to WR with the beat counter at 0. ufp_write has priority if both requests are high.
  - Otherwise ufp_read goes to RD_REQ.
- WR:
  - Drives bmem_write=1, bmem_addr=latched line address, and bmem_wdata=ufp_wdata[64*cnt +: 64].
  - The counter advances only on cycles where bmem_ready=1.
  - When beat 3 is accepted, go to RESP.
- RD_REQ:
  - Drives bmem_read=1 and bmem_addr=latched line address until bmem_ready=1, then go to RD_WAIT with the counter at 0.
  - bmem_read is high for exactly one accepted cycle.
- RD_WAIT:
  - Each accepted rvalid beat is stored to buffer[64*cnt +: 64], and the counter advances.
  - After beat 3 is stored, go to RESP.
- RESP:
  - ufp_resp=1 for one cycle, then go to IDLE.
  - For a read, ufp_rdata = assembled buffer.
- The requester must deassert its request in the cycle after ufp_resp. The adapter does not sample in RESP, so a stale request is never double-serviced.
- The counter is 2 bits and wraps to 0 on the 4th beat.
- bmem_rvalid outside RD_WAIT is ignored.
- bmem_read and bmem_write are never high together.

## Timing
- Reset values: ufp_resp=0, bmem_read=0, bmem_write=0, counter=0, state=IDLE. ufp_rdata, bmem_addr and bmem_wdata are 0.
- Write with bmem_ready held high, request in IDLE at cycle T:
  - beats at T+1..T+4
  - ufp_resp at T+5
- Read with bmem_ready high, request at T:
  - bmem_read at T+1
  - first rvalid at earliest T+2
  - ufp_resp the cycle after the 4th beat is accepted
- bmem_ready low stalls the current beat or command. Outputs hold unchanged.
- ufp_rdata holds its last value until the next read completes.
- Reset asserted mid-transaction: at the next edge the adapter is in IDLE with all outputs deasserted. A partial burst is abandoned, and no ufp_resp is issued for it.

## Configuration
- CACHELINE_ADAPTER_RADDR_CHECK_EN
- Defined: a beat in RD_WAIT is accepted only if bmem_rvalid=1 and bmem_raddr[31:5] equals the latched line[31:5]. Mismatched beats are dropped and do not advance the counter.
- Undefined: every bmem_rvalid beat in RD_WAIT is accepted, and bmem_raddr is unused.

## Test plan
- Write 0x0000_1040, wdata = {64'h4, 64'h3, 64'h2, 64'h1}, bmem_ready=1 -> bmem_addr=0x0000_1040 on 4 beats with data 1, 2, 3, 4 in order; ufp_resp 5 cycles after the request.
- Read 0x8000_00E4, memory returns beats A, B, C, D three cycles after the command -> bmem_addr=0x8000_00E0; ufp_rdata = {D, C, B, A}; a single ufp_resp pulse.
- Write with bmem_ready low for 2 cycles on beat 1 -> beat 1 held for 3 cycles, no beat skipped, ufp_resp delayed 2 cycles.
- ufp_read and ufp_write both high -> write burst issued, no bmem_read.
- rst_n low during beat 2 of a read -> next cycle IDLE with outputs 0; late rvalid beats ignored; a new read completes correctly.
- With CHECK_EN: rvalid with a mismatched raddr between beats 1 and 2 -> dropped; the line assembles from the 4 matching beats only.
